pc_sequencer: RTL

//  Program-counter sequencer for the custom ISA core: owns the PC, steps it each cycle, and redirects it
//  on taken branches through the external branch-target LUT (small index -> 10-bit target).

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/pc_seq_pkg.sv
// Shared state encoding and default configuration for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    localparam int unsigned PC_W_DEF        = 10;
    localparam int unsigned IDX_W_DEF       = 8;
    localparam int unsigned NUM_TARGETS_DEF = 23;
    localparam int unsigned START_ADDR_DEF  = 0;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the PC, redirects it through the external branch-target LUT,
// and reports Done/Fault. Optional link register for Call/Ret is enabled by PC_SEQUENCER_LINK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF,
    parameter int unsigned NUM_TARGETS = NUM_TARGETS_DEF,
    parameter int unsigned START_ADDR  = START_ADDR_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [IDX_W-1:0] BranchIdx,
    input  logic             Call,
    input  logic             Ret,
    output logic [IDX_W-1:0] LutAddr,
    input  logic [PC_W-1:0]  LutTarget,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] CycleCnt
);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
    logic             take, idx_ok;

    assign LutAddr  = BranchIdx;
    assign ProgCtr  = pc_q;
    assign CycleCnt = cnt_q;

    assign pc_inc  = pc_q + PC_W'(1);
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign take    = BranchEn & Taken;
    assign idx_ok  = (32'(BranchIdx) < NUM_TARGETS);

`ifdef PC_SEQUENCER_LINK_EN
    logic [PC_W-1:0] link_q, link_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end
`else
    logic unused_link;
    assign unused_link = ^{Call, Ret};
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(START_ADDR);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // RUN priority: Halt > Ret > taken branch (fault or jump) > step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PC_SEQUENCER_LINK_EN
        link_d  = link_q;
`endif
        unique case (state_q)
            S_RUN: begin
                cnt_d = cnt_sat;
                if (Halt) begin
                    state_d = S_DONE;
`ifdef PC_SEQUENCER_LINK_EN
                end else if (Ret) begin
                    pc_d = link_q;
`endif
                end else if (take && !idx_ok) begin
                    state_d = S_FAULT;
                end else if (take) begin
                    pc_d = LutTarget;
`ifdef PC_SEQUENCER_LINK_EN
                    if (Call) begin
                        link_d = pc_inc;
                    end
`endif
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = PC_W'(START_ADDR);
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        Running = (state_q == S_RUN);
        Done    = (state_q == S_DONE) || (state_q == S_FAULT);
        Fault   = (state_q == S_FAULT);
    end

endmodule
